uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 Parameter PARITY_EN, default 0, 1 inserts one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 baud_enable  input  1  one-clk pulse per bit period, from the baud-rate generator.
REQ-009 t_enable  input  1  write strobe; pushes data into the FIFO.
REQ-010 data  input  DATA_W  word to transmit; sampled when t_enable=1.
REQ-011 txd  output  1  serial line; idles high.
REQ-012 tbr  output  1  transmit buffer ready, high when the FIFO is not full.
REQ-013 tx_idle  output  1  high when the FSM is in IDLE and the FIFO is empty.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
REQ-015 overflow  output  1  sticky; set by a write attempted while full.

Function
REQ-016 The frame SHALL be: start bit (0), DATA_W data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; all transitions occur only on clk edges where baud_enable=1.
REQ-018 On IDLE with FIFO non-empty and baud_enable=1, the FSM SHALL pop the head word into the shift register, drive txd=0 and enter START on the same edge.
REQ-019 On IDLE with baud_enable=0, or with an empty FIFO, the FSM SHALL hold, with txd=1.
REQ-020 Each bit SHALL be held on txd for exactly one baud_enable interval; a frame lasts 1+DATA_W+PARITY_EN+STOP_BITS intervals.
REQ-021 Transitions: START->DATA; DATA->DATA until DATA_W bits are sent, then PARITY if PARITY_EN else STOP; PARITY->STOP; STOP->STOP until STOP_BITS are sent.
REQ-022 At the end of the final stop bit, the FSM SHALL pop and emit the next start bit on the same edge if the FIFO is non-empty (back-to-back, no idle gap); otherwise it SHALL enter IDLE.
REQ-023 The parity bit SHALL equal the XOR of the data bits, inverted when PARITY_ODD=1.
REQ-024 txd SHALL be driven directly from a flop (glitch-free).
REQ-025 A write SHALL be accepted if and only if tbr=1 in that cycle; the FIFO SHALL keep the accepted word order.
REQ-026 A write and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-027 A write with t_enable=1 and tbr=0 SHALL be dropped and SHALL set overflow=1; the FIFO contents and fifo_count are unchanged.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 tbr and fifo_count SHALL reflect registered state (update one cycle after a push or pop).
REQ-030 A change of data while no write is being accepted SHALL not affect any queued or in-flight word.

Reset
REQ-031 Reset SHALL force: FSM=IDLE, txd=1, FIFO empty, fifo_count=0, tbr=1, tx_idle=1, overflow=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame and drive txd=1 on the next edge; queued words are discarded.
REQ-033 Reset SHALL take priority over t_enable and baud_enable.

Verification
REQ-034 Defaults; write 0xA5; baud_enable every 16 clks -> txd sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clks; then tx_idle=1.
REQ-035 PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2; write 0x07 -> 0,1,1,1,0,0,0,0,0,parity=1,1,1.
REQ-036 Write 5 words back-to-back with FIFO_DEPTH=4 while idle with no baud_enable -> 4 accepted, tbr=0, 5th dropped, overflow=1.
REQ-037 Queue 0x11,0x22,0x33 -> three frames transmitted contiguously with no idle interval; fifo_count steps 3->2->1->0.
REQ-038 Assert reset during data bit 4 -> next edge txd=1, fifo_count=0, tbr=1, overflow=0.
REQ-039 With the FIFO full, write on the same cycle as a pop -> write accepted, fifo_count remains 4, overflow stays 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with a small transmit FIFO in front of it. Words written
//   with t_enable are queued and sent as frames: start bit (0), DATA_W data
//   bits LSB first, optional parity bit, STOP_BITS stop bits (1). Bit timing
//   comes entirely from the baud_enable pulse; the FSM only advances on clk
//   edges where baud_enable=1.
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   FIFO_DEPTH  FIFO entries, power of two (2..16)
//   PARITY_EN   1 inserts a parity bit after the data bits
//   PARITY_ODD  1 selects odd parity, 0 even (ignored when PARITY_EN=0)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   baud_enable  in   one-clk pulse per bit period
//   t_enable     in   write strobe
//   data         in   word to queue, sampled when t_enable=1
//   txd          out  serial line, idles high, driven from a flop
//   tbr          out  FIFO not full
//   tx_idle      out  FSM idle and FIFO empty
//   fifo_count   out  occupied FIFO entries
//   overflow     out  sticky, set by a write attempted while full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_enable,
    input  logic                          t_enable,
    input  logic [DATA_W-1:0]             data,
    output logic                          txd,
    output logic                          tbr,
    output logic                          tx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    // -----------------------------------------------------------------------
    // Transmit FSM state
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BCW-1:0]    r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_parity;
    logic              r_txd;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_head_parity;
    logic              w_last_stop;
    logic              w_pop;
    logic              w_push;

    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_head        = r_mem[r_rd_ptr];
    // Parity is computed from the word as it leaves the FIFO, so a later
    // change of data cannot disturb the frame in flight.
    assign w_head_parity = (^w_head) ^ (PARITY_ODD != 0);
    assign w_last_stop   = (r_state == S_STOP) && (r_stop_cnt == 1'(STOP_BITS - 1));

    // A pop happens when the FSM starts a frame: from IDLE, or at the end of
    // the final stop bit (back-to-back frames).
    assign w_pop  = baud_enable && !w_empty && ((r_state == S_IDLE) || w_last_stop);

    // A write into a full FIFO is still accepted when a pop frees a slot on
    // the same edge; the freed slot is the one the write pointer addresses,
    // and the pop reads the old contents before the write lands.
    assign w_push = t_enable && (!w_full || w_pop);

    // -----------------------------------------------------------------------
    // FIFO memory write (no reset needed: pointers define validity)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (t_enable && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM; txd is registered here so the line never glitches.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
        end else if (baud_enable) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= w_head_parity;
                        r_txd    <= 1'b0;
                        r_state  <= S_START;
                    end else begin
                        r_txd    <= 1'b1;
                    end
                end

                S_START: begin
                    // Data bit 0 goes out; the shift register then presents
                    // the next bit at bit 0.
                    r_txd     <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= S_DATA;
                end

                S_DATA: begin
                    // r_bit_cnt is the index of the data bit currently on txd.
                    if (r_bit_cnt == BCW'(DATA_W - 1)) begin
                        if (PARITY_EN != 0) begin
                            r_txd   <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_txd      <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= S_STOP;
                        end
                    end else begin
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end

                S_PARITY: begin
                    r_txd      <= 1'b1;
                    r_stop_cnt <= 1'b0;
                    r_state    <= S_STOP;
                end

                S_STOP: begin
                    if (w_last_stop) begin
                        if (w_pop) begin
                            r_shift  <= w_head;
                            r_parity <= w_head_parity;
                            r_txd    <= 1'b0;
                            r_state  <= S_START;
                        end else begin
                            r_txd    <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_txd      <= 1'b1;
                        r_stop_cnt <= 1'b1;
                    end
                end

                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign txd        = r_txd;
    assign tbr        = !w_full;
    assign tx_idle    = (r_state == S_IDLE) && w_empty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       t_enable = 1'b0;
    logic       t_enable1 = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       baud_gen = 1'b0;
    logic       baud_manual = 1'b0;
    logic       baud_run = 1'b0;
    logic       baud_enable;

    logic       txd, tbr, tx_idle, overflow;
    logic [2:0] fifo_count;
    logic       txd1, tbr1, tx_idle1, overflow1;
    logic [2:0] fifo_count1;

    int checks = 0;
    int errors = 0;
    logic q[$];

    assign baud_enable = baud_gen | baud_manual;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_W(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .reset(reset), .baud_enable(baud_enable),
        .t_enable(t_enable), .data(data),
        .txd(txd), .tbr(tbr), .tx_idle(tx_idle),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    uart_tx_fifo #(
        .DATA_W(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_par (
        .clk(clk), .reset(reset), .baud_enable(baud_enable),
        .t_enable(t_enable1), .data(data1),
        .txd(txd1), .tbr(tbr1), .tx_idle(tx_idle1),
        .fifo_count(fifo_count1), .overflow(overflow1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] d);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        q.push_back(1'b1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string name);
        logic found;
        logic tk;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            tk = baud_enable;
            #1;
            if (tk) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(q.size() == 0 && tx_idle) && n < 4000) begin
            data = 8'($urandom);
            cyc();
            n++;
        end
        check(name, 32'(n < 4000), 32'd1);
    endtask

    // Baud generator: one pulse every 16 clocks while baud_run is set.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (baud_run) begin
                if (cnt == 15) begin
                    baud_gen = 1'b1;
                    cnt = 0;
                end else begin
                    baud_gen = 1'b0;
                    cnt++;
                end
            end else begin
                baud_gen = 1'b0;
                cnt = 0;
            end
        end
    end

    // Line monitor for the default DUT: each baud tick pops the next
    // expected bit; between ticks the line must not move.
    initial begin
        logic last;
        logic rs;
        logic tk;
        last = 1'b1;
        forever begin
            @(posedge clk);
            rs = reset;
            tk = baud_enable;
            #1;
            if (rs) begin
                last = txd;
            end else if (tk) begin
                if (q.size() > 0) begin
                    logic e;
                    e = q.pop_front();
                    check("txd_bit", 32'(txd), 32'(e));
                end else begin
                    check("txd_idle_tick", 32'(txd), 32'd1);
                end
                last = txd;
            end else begin
                check("txd_hold", 32'(txd), 32'(last));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] d;
        logic       acc;
        logic [2:0] cnt;
        logic       tbr;
        logic       ovf;
        logic       idle;
    } vec_t;

    initial begin
        vec_t tv[12];
        logic exp35[12];
        int   n;

        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 8'hB2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 8'hD4, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 8'hE5, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 8'h5A, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 8'h11, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 8'h22, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 8'h33, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 8'h44, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};

        exp35 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        cyc();
        cyc();

        // Table: reset state, FIFO fill, overflow drop, reset priority.
        for (int i = 0; i < 12; i++) begin
            reset    = tv[i].rst;
            t_enable = tv[i].we;
            data     = tv[i].d;
            cyc();
            if (tv[i].rst) q.delete();
            if (tv[i].acc) push_frame(tv[i].d);
            check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(tv[i].cnt));
            check($sformatf("v%0d_tbr", i), 32'(tbr), 32'(tv[i].tbr));
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tv[i].ovf));
            check($sformatf("v%0d_tx_idle", i), 32'(tx_idle), 32'(tv[i].idle));
            check($sformatf("v%0d_txd", i), 32'(txd), 32'd1);
        end
        reset    = 1'b0;
        t_enable = 1'b0;

        // Full FIFO: write on the same edge as the pop of the head word.
        baud_manual = 1'b1;
        t_enable    = 1'b1;
        data        = 8'h55;
        cyc();
        baud_manual = 1'b0;
        t_enable    = 1'b0;
        push_frame(8'h55);
        check("r39_count", 32'(fifo_count), 32'd4);
        check("r39_overflow", 32'(overflow), 32'd0);
        check("r39_tbr", 32'(tbr), 32'd0);
        check("r39_start", 32'(txd), 32'd0);
        baud_run = 1'b1;
        wait_drain("r39_drain");
        baud_run = 1'b0;
        repeat (3) cyc();

        // Single frame 0xA5 with a 16-clock baud period.
        t_enable = 1'b1;
        data     = 8'hA5;
        cyc();
        t_enable = 1'b0;
        push_frame(8'hA5);
        baud_run = 1'b1;
        n = 0;
        while (txd !== 1'b0 && n < 40) begin cyc(); n++; end
        check("r34_start_seen", 32'(n < 40), 32'd1);
        n = 0;
        while (!tx_idle && n < 400) begin cyc(); n++; end
        check("r34_frame_clocks", 32'(n), 32'd160);
        check("r34_tx_idle", 32'(tx_idle), 32'd1);
        wait_drain("r34_drain");
        baud_run = 1'b0;
        repeat (3) cyc();

        // Three queued words go out back-to-back.
        for (int i = 0; i < 3; i++) begin
            t_enable = 1'b1;
            data     = 8'(8'h11 * (i + 1));
            cyc();
            push_frame(8'(8'h11 * (i + 1)));
        end
        t_enable = 1'b0;
        check("r37_count3", 32'(fifo_count), 32'd3);
        baud_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [2:0] prev;
            prev = fifo_count;
            n = 0;
            while (fifo_count == prev && n < 400) begin cyc(); n++; end
            check($sformatf("r37_count_step%0d", k), 32'(fifo_count), 32'(2 - k));
        end
        wait_drain("r37_drain");
        baud_run = 1'b0;
        repeat (3) cyc();

        // Reset in the middle of data bit 4; the second queued word is lost.
        t_enable = 1'b1;
        data     = 8'hA5;
        cyc();
        push_frame(8'hA5);
        data = 8'h3C;
        cyc();
        push_frame(8'h3C);
        t_enable = 1'b0;
        baud_run = 1'b1;
        n = 0;
        while (txd !== 1'b0 && n < 40) begin cyc(); n++; end
        check("r38_start_seen", 32'(n < 40), 32'd1);
        for (int t = 0; t < 5; t++) wait_tick($sformatf("r38_tick%0d", t));
        repeat (8) cyc();
        check("r38_bit4", 32'(txd), 32'd0);
        reset = 1'b1;
        q.delete();
        cyc();
        check("r38_txd", 32'(txd), 32'd1);
        check("r38_count", 32'(fifo_count), 32'd0);
        check("r38_tbr", 32'(tbr), 32'd1);
        check("r38_overflow", 32'(overflow), 32'd0);
        check("r38_tx_idle", 32'(tx_idle), 32'd1);
        reset = 1'b0;
        repeat (100) cyc();
        check("r38_still_idle", 32'(tx_idle), 32'd1);

        // Parity frame on the second instance: even parity, two stop bits.
        t_enable1 = 1'b1;
        data1     = 8'h07;
        cyc();
        t_enable1 = 1'b0;
        data1     = 8'hFF;
        n = 0;
        while (txd1 !== 1'b0 && n < 4) begin
            wait_tick("r35_wait_tick");
            n++;
        end
        check("r35_start", 32'(txd1), 32'd0);
        for (int i = 1; i < 12; i++) begin
            wait_tick("r35_tick");
            check($sformatf("r35_bit%0d", i), 32'(txd1), 32'(exp35[i]));
        end
        wait_tick("r35_end_tick");
        check("r35_tx_idle", 32'(tx_idle1), 32'd1);
        check("r35_txd_idle", 32'(txd1), 32'd1);
        check("r35_count", 32'(fifo_count1), 32'd0);
        check("r35_tbr", 32'(tbr1), 32'd1);
        check("r35_overflow", 32'(overflow1), 32'd0);
        baud_run = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
